// File: rtl/key_debouncer_if.sv
// Signal bundle between a raw pushbutton source and the key debouncer.
// Plain level signals with no valid/ready: key_raw is sampled every Clock, out/state_dbg are registered levels.
interface key_debouncer_if;
  logic       key_raw;
  logic       out;
  logic [1:0] state_dbg;

  modport master (
    output key_raw,
    input  out,
    input  state_dbg
  );

  modport slave (
    input  key_raw,
    output out,
    output state_dbg
  );
endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus counter-qualified 4-state FSM that turns a bouncy
// pushbutton into a clean active-high "pressed" level.
module key_debouncer #(
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic           Clock,
  input logic           Reset,
  key_debouncer_if.slave bus
);

  localparam logic [1:0] RELEASED     = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;

  localparam logic                 REL_LVL  = ACTIVE_LOW;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s1_q, s2_q;
  logic                 pressed_s;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;

  // Synchronizer resets to the released level so no phantom press appears after reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= bus.key_raw;
      s2_q <= s1_q;
    end
  end

  assign pressed_s = s2_q ^ REL_LVL;

  // A revert on the terminal-count cycle is checked first, so it beats acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      RELEASED: begin
        out_d = 1'b0;
        cnt_d = '0;
        if (pressed_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        out_d = 1'b0;
        if (!pressed_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        out_d = 1'b1;
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        out_d = 1'b1;
        if (pressed_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        out_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.state_dbg = state_q;

endmodule
